// File: rtl/floo_nw_link_stage.sv
// floo_nw_link_stage: elastic register stage for one narrow-wide link.
// Three independent FIFOs cut valid/ready/data paths; optional perf counters.
module floo_nw_link_ch #(
    parameter int unsigned Depth     = 2,
    parameter bit          EnPerfCnt = 1'b1,
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned Width     = 64,
    localparam int unsigned FillW    = $clog2(Depth + 1),
    localparam int unsigned PtrW     = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [Width-1:0]    data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [Width-1:0]    data_o,
    output logic [FillW-1:0]    fill_o,
    output logic [CntWidth-1:0] flit_cnt_o,
    output logic [CntWidth-1:0] stall_cnt_o
);
    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rd_ptr, wr_ptr;
    logic [FillW-1:0] fill;
    logic             rdy_q, push, pop;

    // rdy_q keeps ready low during reset and for the first edge after it
    assign ready_o = rdy_q && (fill < FillW'(Depth));
    assign valid_o = (fill != '0);
    assign data_o  = mem[rd_ptr];
    assign fill_o  = fill;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) wr_ptr <= incr(wr_ptr);
            if (pop)  rd_ptr <= incr(rd_ptr);
            if (push && !pop)      fill <= fill + FillW'(1);
            else if (!push && pop) fill <= fill - FillW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    if (EnPerfCnt) begin : g_cnt
        logic [CntWidth-1:0] flit_q, stall_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                flit_q  <= '0;
                stall_q <= '0;
            end else if (clr_i) begin
                flit_q  <= '0;
                stall_q <= '0;
            end else begin
                if (pop && flit_q != '1)
                    flit_q <= flit_q + CntWidth'(1);
                if (valid_o && !ready_i && stall_q != '1)
                    stall_q <= stall_q + CntWidth'(1);
            end
        end

        assign flit_cnt_o  = flit_q;
        assign stall_cnt_o = stall_q;
    end else begin : g_no_cnt
        logic unused_clr;
        assign unused_clr  = clr_i;
        assign flit_cnt_o  = '0;
        assign stall_cnt_o = '0;
    end

`ifndef SYNTHESIS
    a_depth: assert property (@(posedge clk_i) Depth >= 2);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fill == FillW'(Depth)));
    a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif
endmodule

module floo_nw_link_stage #(
    parameter int unsigned Depth     = 2,
    parameter bit          EnPerfCnt = 1'b1,
    parameter int unsigned CntWidth  = 32,
    parameter type floo_req_chan_t   = logic [63:0],
    parameter type floo_rsp_chan_t   = logic [39:0],
    parameter type floo_wide_chan_t  = logic [255:0],
    localparam int unsigned FillW    = $clog2(Depth + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  floo_req_chan_t            req_data_i,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output floo_req_chan_t            req_data_o,
    input  logic                      rsp_valid_i,
    output logic                      rsp_ready_o,
    input  floo_rsp_chan_t            rsp_data_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output floo_rsp_chan_t            rsp_data_o,
    input  logic                      wide_valid_i,
    output logic                      wide_ready_o,
    input  floo_wide_chan_t           wide_data_i,
    output logic                      wide_valid_o,
    input  logic                      wide_ready_i,
    output floo_wide_chan_t           wide_data_o,
    output logic [2:0][FillW-1:0]     fill_o,
    output logic [2:0][CntWidth-1:0]  flit_cnt_o,
    output logic [2:0][CntWidth-1:0]  stall_cnt_o
);
    floo_nw_link_ch #(
        .Depth(Depth), .EnPerfCnt(EnPerfCnt), .CntWidth(CntWidth),
        .Width($bits(floo_req_chan_t))
    ) i_req (
        .clk_i, .rst_ni, .clr_i,
        .valid_i(req_valid_i), .ready_o(req_ready_o), .data_i(req_data_i),
        .valid_o(req_valid_o), .ready_i(req_ready_i), .data_o(req_data_o),
        .fill_o(fill_o[0]), .flit_cnt_o(flit_cnt_o[0]),
        .stall_cnt_o(stall_cnt_o[0])
    );

    floo_nw_link_ch #(
        .Depth(Depth), .EnPerfCnt(EnPerfCnt), .CntWidth(CntWidth),
        .Width($bits(floo_rsp_chan_t))
    ) i_rsp (
        .clk_i, .rst_ni, .clr_i,
        .valid_i(rsp_valid_i), .ready_o(rsp_ready_o), .data_i(rsp_data_i),
        .valid_o(rsp_valid_o), .ready_i(rsp_ready_i), .data_o(rsp_data_o),
        .fill_o(fill_o[1]), .flit_cnt_o(flit_cnt_o[1]),
        .stall_cnt_o(stall_cnt_o[1])
    );

    floo_nw_link_ch #(
        .Depth(Depth), .EnPerfCnt(EnPerfCnt), .CntWidth(CntWidth),
        .Width($bits(floo_wide_chan_t))
    ) i_wide (
        .clk_i, .rst_ni, .clr_i,
        .valid_i(wide_valid_i), .ready_o(wide_ready_o), .data_i(wide_data_i),
        .valid_o(wide_valid_o), .ready_i(wide_ready_i), .data_o(wide_data_o),
        .fill_o(fill_o[2]), .flit_cnt_o(flit_cnt_o[2]),
        .stall_cnt_o(stall_cnt_o[2])
    );
endmodule

// File: tb/tb_floo_nw_link_stage.sv
// tb_floo_nw_link_stage: random traffic against a queue-based link model,
// plus a narrow-counter instance for saturation and clear.
module tb_floo_nw_link_stage;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ni, clr_a, clr_b;
    logic [2:0] vi, ri, vo, ro;
    logic [255:0] dpend [3];
    logic [63:0] req_do;
    logic [39:0] rsp_do;
    logic [255:0] wide_do;
    logic [2:0][1:0] fill;
    logic [2:0][31:0] fcnt, scnt;

    logic [2:0] b_vi, b_ri, b_vo, b_ro;
    logic [255:0] b_din;
    logic [63:0] b_req_do;
    logic [39:0] b_rsp_do;
    logic [255:0] b_wide_do;
    logic [2:0][1:0] b_fill;
    logic [2:0][3:0] b_fcnt, b_scnt;

    floo_nw_link_stage #(.Depth(2), .EnPerfCnt(1'b1), .CntWidth(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_a),
        .req_valid_i(vi[0]), .req_ready_o(ro[0]), .req_data_i(dpend[0][63:0]),
        .req_valid_o(vo[0]), .req_ready_i(ri[0]), .req_data_o(req_do),
        .rsp_valid_i(vi[1]), .rsp_ready_o(ro[1]), .rsp_data_i(dpend[1][39:0]),
        .rsp_valid_o(vo[1]), .rsp_ready_i(ri[1]), .rsp_data_o(rsp_do),
        .wide_valid_i(vi[2]), .wide_ready_o(ro[2]), .wide_data_i(dpend[2]),
        .wide_valid_o(vo[2]), .wide_ready_i(ri[2]), .wide_data_o(wide_do),
        .fill_o(fill), .flit_cnt_o(fcnt), .stall_cnt_o(scnt)
    );

    floo_nw_link_stage #(.Depth(2), .EnPerfCnt(1'b1), .CntWidth(4)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_b),
        .req_valid_i(b_vi[0]), .req_ready_o(b_ro[0]), .req_data_i(b_din[63:0]),
        .req_valid_o(b_vo[0]), .req_ready_i(b_ri[0]), .req_data_o(b_req_do),
        .rsp_valid_i(b_vi[1]), .rsp_ready_o(b_ro[1]), .rsp_data_i(b_din[39:0]),
        .rsp_valid_o(b_vo[1]), .rsp_ready_i(b_ri[1]), .rsp_data_o(b_rsp_do),
        .wide_valid_i(b_vi[2]), .wide_ready_o(b_ro[2]), .wide_data_i(b_din),
        .wide_valid_o(b_vo[2]), .wide_ready_i(b_ri[2]), .wide_data_o(b_wide_do),
        .fill_o(b_fill), .flit_cnt_o(b_fcnt), .stall_cnt_o(b_scnt)
    );

    // reference model: one FIFO queue and two counters per channel
    logic [255:0] mq [3][$];
    longint mflit [3];
    longint mstall [3];
    bit mrdy;
    bit obs_push [3];
    bit obs_pop [3];
    int pv [3];
    int pr [3];
    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] trunc(int c, logic [255:0] d);
        case (c)
            0: return {192'b0, d[63:0]};
            1: return {216'b0, d[39:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [255:0] dout(int c);
        case (c)
            0: return {192'b0, req_do};
            1: return {216'b0, rsp_do};
            default: return wide_do;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mq[c].delete();
            mflit[c] = 0;
            mstall[c] = 0;
            obs_push[c] = 1'b0;
            obs_pop[c] = 1'b0;
        end
        mrdy = 1'b0;
    endtask

    // offer a flit; a flit not yet accepted is held unchanged
    task automatic offer(int c, bit want);
        if (!(vi[c] && !obs_push[c])) begin
            vi[c] = want;
            dpend[c] = rnd256();
        end
    endtask

    task automatic drive();
        for (int c = 0; c < 3; c++) begin
            offer(c, $urandom_range(99) < pv[c]);
            ri[c] = ($urandom_range(99) < pr[c]);
        end
    endtask

    // one clock: compare DUT with the model mid-cycle, then advance both
    task automatic step();
        bit push [3];
        bit pop [3];
        bit stl [3];
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            int sz;
            sz = mq[c].size();
            n_tests++;
            if (vo[c] !== (sz != 0)) begin
                n_fail++;
                $display("FAIL valid_o ch%0d: got %b want %b", c, vo[c], sz != 0);
            end
            n_tests++;
            if (ro[c] !== (mrdy && sz < DEPTH)) begin
                n_fail++;
                $display("FAIL ready_o ch%0d: got %b want %b", c, ro[c],
                         mrdy && sz < DEPTH);
            end
            n_tests++;
            if (fill[c] !== 2'(sz)) begin
                n_fail++;
                $display("FAIL fill_o ch%0d: got %0d want %0d", c, fill[c], sz);
            end
            n_tests++;
            if (fcnt[c] !== 32'(mflit[c])) begin
                n_fail++;
                $display("FAIL flit_cnt ch%0d: got %0d want %0d", c, fcnt[c], mflit[c]);
            end
            n_tests++;
            if (scnt[c] !== 32'(mstall[c])) begin
                n_fail++;
                $display("FAIL stall_cnt ch%0d: got %0d want %0d", c, scnt[c],
                         mstall[c]);
            end
            if (sz != 0 && vo[c] === 1'b1) begin
                n_tests++;
                if (dout(c) !== mq[c][0]) begin
                    n_fail++;
                    $display("FAIL data_o ch%0d: got %0h want %0h", c, dout(c),
                             mq[c][0]);
                end
            end
            obs_push[c] = vi[c] && ro[c];
            obs_pop[c] = vo[c] && ri[c];
            push[c] = vi[c] && mrdy && sz < DEPTH;
            pop[c] = (sz != 0) && ri[c];
            stl[c] = (sz != 0) && !ri[c];
        end
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            if (pop[c]) void'(mq[c].pop_front());
            if (push[c]) mq[c].push_back(trunc(c, dpend[c]));
            if (clr_a) begin
                mflit[c] = 0;
                mstall[c] = 0;
            end else begin
                if (pop[c]) mflit[c]++;
                if (stl[c]) mstall[c]++;
            end
        end
        mrdy = 1'b1;
        #1;
    endtask

    task automatic idle_drain(int n);
        ri = 3'b111;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 3; c++) offer(c, 1'b0);
            step();
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (vo !== 3'b000 || b_vo !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b/%b want 000", vo, b_vo);
        end
        n_tests++;
        if (ro !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 000", ro);
        end
        n_tests++;
        if (fill !== '0 || fcnt !== '0 || scnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: fill %h fcnt %h scnt %h want 0", fill, fcnt,
                     scnt);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        model_reset();
        step();
        step();
        n_tests++;
        if (ro !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b want 111", ro);
        end
    endtask

    task automatic test_stream();
        int acc = 0;
        int got = 0;
        int acc100 = 0;
        ri = 3'b111;
        for (int k = 0; k < 104; k++) begin
            offer(0, acc < 100);
            offer(1, 1'b0);
            offer(2, 1'b0);
            step();
            if (obs_push[0]) acc++;
            if (obs_pop[0]) got++;
            if (k == 99) acc100 = acc;
        end
        n_tests++;
        if (acc100 !== 100) begin
            n_fail++;
            $display("FAIL stream_rate: got %0d accepted in 100 cycles want 100", acc100);
        end
        n_tests++;
        if (got !== 100 || fcnt[0] !== 32'd100) begin
            n_fail++;
            $display("FAIL stream_count: got %0d/%0d want 100", got, fcnt[0]);
        end
        n_tests++;
        if (scnt[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL stream_stall: got %0d want 0", scnt[0]);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [31:0] s0;
        ri = 3'b011;
        for (int k = 0; k < 3; k++) begin
            offer(0, 1'b0);
            offer(1, 1'b0);
            offer(2, 1'b1);
            step();
            if (obs_push[2]) acc++;
        end
        n_tests++;
        if (acc !== 2 || ro[2] !== 1'b0 || fill[2] !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_full: got acc %0d ready %b fill %0d want 2 0 2", acc,
                     ro[2], fill[2]);
        end
        s0 = scnt[2];
        for (int k = 1; k <= 4; k++) begin
            step();
            n_tests++;
            if (scnt[2] !== s0 + 32'(k)) begin
                n_fail++;
                $display("FAIL bp_stall: got %0d want %0d", scnt[2], s0 + 32'(k));
            end
        end
        ri[2] = 1'b1;
        step();
        n_tests++;
        if (obs_push[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pop_cycle_ready: got %b want 0", obs_push[2]);
        end
        step();
        n_tests++;
        if (obs_push[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_after_pop: got %b want 1", obs_push[2]);
        end
        idle_drain(4);
        n_tests++;
        if (fill[2] !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d want 0", fill[2]);
        end
    endtask

    task automatic test_independence();
        int p0 = 0;
        int p2 = 0;
        logic [31:0] s0;
        ri = 3'b101;
        for (int c = 0; c < 3; c++) offer(c, 1'b1);
        step();
        s0 = scnt[1];
        for (int k = 0; k < 20; k++) begin
            offer(0, 1'b1);
            offer(1, 1'b0);
            offer(2, 1'b1);
            step();
            if (obs_pop[0]) p0++;
            if (obs_pop[2]) p2++;
        end
        n_tests++;
        if (p0 !== 20 || p2 !== 20) begin
            n_fail++;
            $display("FAIL indep_throughput: got %0d/%0d want 20", p0, p2);
        end
        n_tests++;
        if (scnt[1] - s0 !== 32'd20) begin
            n_fail++;
            $display("FAIL indep_rsp_stall: got %0d want 20", scnt[1] - s0);
        end
        idle_drain(4);
    endtask

    task automatic test_random();
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 3; c++) begin
                pv[c] = int'($urandom_range(100));
                pr[c] = int'($urandom_range(100));
            end
            for (int k = 0; k < 50; k++) begin
                drive();
                step();
            end
        end
        idle_drain(5);
        n_tests++;
        if (fill !== '0) begin
            n_fail++;
            $display("FAIL random_drain: got %h want 0", fill);
        end
    endtask

    task automatic test_counters();
        int bp = 0;
        int guard = 0;
        b_ri = 3'b001;
        while (bp < 20 && guard < 40) begin
            b_vi[0] = 1'b1;
            b_din = rnd256();
            @(negedge clk);
            if (b_vi[0] && b_ro[0]) bp++;
            @(posedge clk);
            #1;
            guard++;
        end
        b_vi[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (bp !== 20) begin
            n_fail++;
            $display("FAIL cnt_pushes: got %0d want 20", bp);
        end
        n_tests++;
        if (b_fcnt[0] !== 4'd15) begin
            n_fail++;
            $display("FAIL cnt_flit_sat: got %0d want 15", b_fcnt[0]);
        end
        b_ri[0] = 1'b0;
        b_vi[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        b_vi[0] = 1'b0;
        n_tests++;
        if (b_scnt[0] !== 4'd15 || b_fcnt[0] !== 4'd15) begin
            n_fail++;
            $display("FAIL cnt_stall_sat: got %0d/%0d want 15/15", b_scnt[0], b_fcnt[0]);
        end
        n_tests++;
        if (b_scnt[1] !== 4'd0 || b_fcnt[2] !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_idle_ch: got %0d/%0d want 0", b_scnt[1], b_fcnt[2]);
        end
        b_ri[0] = 1'b1;
        clr_b = 1'b1;
        @(posedge clk);
        #1;
        clr_b = 1'b0;
        n_tests++;
        if (b_fcnt[0] !== 4'd0 || b_scnt[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_clear: got %0d/%0d want 0/0", b_fcnt[0], b_scnt[0]);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (b_fcnt[0] !== 4'd1) begin
            n_fail++;
            $display("FAIL cnt_after_clear: got %0d want 1", b_fcnt[0]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mid_reset();
        ri = 3'b000;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 3; c++) offer(c, 1'b1);
            step();
        end
        n_tests++;
        if (fill !== {2'd2, 2'd2, 2'd2}) begin
            n_fail++;
            $display("FAIL midrst_prefill: got %h want 2 per channel", fill);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_tests++;
        if (vo !== 3'b000 || ro !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_async: got valid %b ready %b want 000", vo, ro);
        end
        n_tests++;
        if (fill !== '0 || fcnt !== '0 || scnt !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: fill %h fcnt %h scnt %h want 0", fill, fcnt,
                     scnt);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        vi = 3'b000;
        ri = 3'b111;
        model_reset();
        repeat (4) step();
    endtask

    initial begin
        rst_ni = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        vi = '0;
        ri = '0;
        b_vi = '0;
        b_ri = '0;
        b_din = '0;
        for (int c = 0; c < 3; c++) begin
            dpend[c] = '0;
            pv[c] = 0;
            pr[c] = 100;
        end
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_independence();
        test_random();
        test_counters();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
